// File: rtl/wb_interconnect_if.sv
// Wishbone classic bus bundle between one master, the interconnect and NUM_SLAVES slaves.
// The interconnect uses the slave modport; the environment that drives the master side and answers as the slaves uses the master modport.
`timescale 1ns/1ps
interface wb_interconnect_if #(
   parameter int NUM_SLAVES = 5,
   parameter int ADDR_SIZE  = 32,
   parameter int DATA_SIZE  = 32
);
   // Handshake: a transfer is requested while CYC&STB are high and completes on the
   // single cycle where ACK_O or ERR_O is high; the master holds ADR/DAT/WE/SEL stable until then.
   logic [ADDR_SIZE-1:0]            ADR_I;
   logic [DATA_SIZE-1:0]            DAT_I;
   logic [DATA_SIZE-1:0]            DAT_O;
   logic                            CYC_I;
   logic                            STB_I;
   logic                            WE_I;
   logic [DATA_SIZE/8-1:0]          SEL_I;
   logic                            ACK_O;
   logic                            ERR_O;
   logic [ADDR_SIZE-1:0]            s_ADR_O;
   logic [DATA_SIZE-1:0]            s_DAT_O;
   logic                            s_WE_O;
   logic [DATA_SIZE/8-1:0]          s_SEL_O;
   logic [NUM_SLAVES-1:0]           s_CYC_O;
   logic [NUM_SLAVES-1:0]           s_STB_O;
   logic [NUM_SLAVES*DATA_SIZE-1:0] s_DAT_I;
   logic [NUM_SLAVES-1:0]           s_ACK_I;

   modport slave (
      input  ADR_I, DAT_I, CYC_I, STB_I, WE_I, SEL_I, s_DAT_I, s_ACK_I,
      output DAT_O, ACK_O, ERR_O, s_ADR_O, s_DAT_O, s_WE_O, s_SEL_O, s_CYC_O, s_STB_O
   );

   modport master (
      output ADR_I, DAT_I, CYC_I, STB_I, WE_I, SEL_I, s_DAT_I, s_ACK_I,
      input  DAT_O, ACK_O, ERR_O, s_ADR_O, s_DAT_O, s_WE_O, s_SEL_O, s_CYC_O, s_STB_O
   );
endinterface

// File: rtl/wb_interconnect.sv
// Single-master, N-slave Wishbone classic interconnect with base/mask decode and bus error on unmapped addresses.
// Optional slave-ACK timeout is built when WB_INTERCONNECT_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module wb_interconnect #(
   parameter int NUM_SLAVES = 5,
   parameter int ADDR_SIZE  = 32,
   parameter int DATA_SIZE  = 32,
   parameter logic [NUM_SLAVES*ADDR_SIZE-1:0] SLAVE_BASE =
      {32'hF0C00000, 32'hF0000000, 32'h40000000, 32'h10000000, 32'h00000000},
   parameter logic [NUM_SLAVES*ADDR_SIZE-1:0] SLAVE_MASK =
      {32'hFFC00000, 32'hFFFE0000, 32'hFC000000, 32'hFFFFF000, 32'hFFFF0000},
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clock,
   input  logic                 reset,
   wb_interconnect_if.slave     bus,
   output logic [ADDR_SIZE-1:0] err_addr,
   output logic [7:0]           err_count,
   output logic [1:0]           o_state
);
   localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUSY  = 2'd1,
      S_ERROR = 2'd2
   } state_t;

   state_t                r_state;
   logic [IW-1:0]         r_sel_idx;
   logic [NUM_SLAVES-1:0] r_sel_oh;
   logic [ADDR_SIZE-1:0]  r_err_addr;
   logic [7:0]            r_err_count;
   logic                  r_err_o;

   logic                  w_req;
   logic                  w_hit;
   logic [IW-1:0]         w_hit_idx;
   logic [NUM_SLAVES-1:0] w_hit_oh;
   logic                  w_ack;
   logic [7:0]            w_err_count_inc;

`ifdef WB_INTERCONNECT_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   logic [TW-1:0] r_tmo_cnt;
`endif

   assign w_req = bus.CYC_I & bus.STB_I;

   // Descending scan so the lowest matching index is the last one written and wins.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      w_hit_oh  = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if ((bus.ADR_I & SLAVE_MASK[i*ADDR_SIZE +: ADDR_SIZE]) == SLAVE_BASE[i*ADDR_SIZE +: ADDR_SIZE]) begin
            w_hit       = 1'b1;
            w_hit_idx   = IW'(i);
            w_hit_oh    = '0;
            w_hit_oh[i] = 1'b1;
         end
      end
   end

   assign w_ack           = (r_state == S_BUSY) & bus.s_ACK_I[r_sel_idx] & w_req;
   assign w_err_count_inc = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;

   assign bus.s_ADR_O = bus.ADR_I;
   assign bus.s_DAT_O = bus.DAT_I;
   assign bus.s_WE_O  = bus.WE_I;
   assign bus.s_SEL_O = bus.SEL_I;
   // Strobes follow the master live so an abort removes them in the same cycle.
   assign bus.s_CYC_O = r_sel_oh & {NUM_SLAVES{w_req}};
   assign bus.s_STB_O = r_sel_oh & {NUM_SLAVES{w_req}};
   assign bus.ACK_O   = w_ack;
   assign bus.ERR_O   = r_err_o;
   assign bus.DAT_O   = (r_state == S_BUSY) ? bus.s_DAT_I[r_sel_idx*DATA_SIZE +: DATA_SIZE] : '0;

   assign err_addr  = r_err_addr;
   assign err_count = r_err_count;
   assign o_state   = r_state;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_sel_idx   <= '0;
         r_sel_oh    <= '0;
         r_err_addr  <= '0;
         r_err_count <= '0;
         r_err_o     <= 1'b0;
`ifdef WB_INTERCONNECT_TIMEOUT_EN
         r_tmo_cnt   <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_err_o <= 1'b0;
               if (w_req) begin
                  if (w_hit) begin
                     r_sel_idx <= w_hit_idx;
                     r_sel_oh  <= w_hit_oh;
                     r_state   <= S_BUSY;
`ifdef WB_INTERCONNECT_TIMEOUT_EN
                     r_tmo_cnt <= '0;
`endif
                  end else begin
                     r_err_addr  <= bus.ADR_I;
                     r_err_count <= w_err_count_inc;
                     r_err_o     <= 1'b1;
                     r_state     <= S_ERROR;
                  end
               end
            end
            S_BUSY: begin
               if (w_ack || !bus.CYC_I) begin
                  r_sel_oh <= '0;
                  r_state  <= S_IDLE;
               end
`ifdef WB_INTERCONNECT_TIMEOUT_EN
               else if (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  r_sel_oh    <= '0;
                  r_err_addr  <= bus.ADR_I;
                  r_err_count <= w_err_count_inc;
                  r_err_o     <= 1'b1;
                  r_state     <= S_ERROR;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
               end
`endif
            end
            S_ERROR: begin
               r_err_o <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_sel_oh <= '0;
               r_err_o  <= 1'b0;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_wb_interconnect.sv
// Self-checking bench for wb_interconnect: random traffic against an address-map/memory reference model,
// plus directed abort, reset, overlap and (with WB_INTERCONNECT_TIMEOUT_EN) timeout cases.
`timescale 1ns/1ps
module tb_wb_interconnect;
  localparam int NS = 5;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [NS*AW-1:0] BASES =
    {32'hF0C00000, 32'hF0000000, 32'h40000000, 32'h10000000, 32'h00000000};
  localparam logic [NS*AW-1:0] MASKS =
    {32'hFFC00000, 32'hFFFE0000, 32'hFC000000, 32'hFFFFF000, 32'hFFFF0000};
`ifdef WB_INTERCONNECT_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_interconnect_if #(.NUM_SLAVES(NS), .ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();
  logic [AW-1:0] err_addr;
  logic [7:0]    err_count;
  logic [1:0]    dbg_state;

  wb_interconnect #(
    .NUM_SLAVES(NS), .ADDR_SIZE(AW), .DATA_SIZE(DW),
    .SLAVE_BASE(BASES), .SLAVE_MASK(MASKS), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clk), .reset(rst), .bus(bus.slave),
    .err_addr(err_addr), .err_count(err_count), .o_state(dbg_state)
  );

  // second instance with two overlapping slaves to exercise lowest-index priority
  wb_interconnect_if #(.NUM_SLAVES(2), .ADDR_SIZE(AW), .DATA_SIZE(DW)) bus2 ();
  logic [AW-1:0] err_addr2;
  logic [7:0]    err_count2;
  logic [1:0]    dbg_state2;

  wb_interconnect #(
    .NUM_SLAVES(2), .ADDR_SIZE(AW), .DATA_SIZE(DW),
    .SLAVE_BASE(64'h0), .SLAVE_MASK({32'hFFFF0000, 32'hFFFF0000}), .TIMEOUT_CYCLES(TMO)
  ) dut2 (
    .clock(clk), .reset(rst), .bus(bus2.slave),
    .err_addr(err_addr2), .err_count(err_count2), .o_state(dbg_state2)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] ref_err_addr = '0;
  int          ref_err_count = 0;

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & MASKS[i*AW +: AW]) == BASES[i*AW +: AW]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] default_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  typedef struct {
    logic        is_err;
    logic        we;
    int          slv;
    logic [31:0] data;
    logic [31:0] eaddr;
    logic [7:0]  ecnt;
  } exp_t;
  exp_t exp_q[$];

  function automatic void model_txn(input logic [31:0] a, input logic we, input logic [3:0] sel, input logic [31:0] d);
    exp_t e;
    int s;
    logic [31:0] cur;
    s = decode(a);
    cur = ref_mem.exists(a) ? ref_mem[a] : default_word(a);
    e.is_err = (s < 0);
    e.we     = we;
    e.slv    = s;
    e.data   = cur;
    if (s < 0) begin
      ref_err_addr = a;
      if (ref_err_count < 255) ref_err_count++;
    end else if (we) begin
      ref_mem[a] = merge(cur, d, sel);
    end
    e.eaddr = ref_err_addr;
    e.ecnt  = 8'(ref_err_count);
    exp_q.push_back(e);
  endfunction

  // ---------------- slave BFMs (memories keyed by slave index and address) ----------------
  logic [31:0]   slv_mem [logic [34:0]];
  logic [NS-1:0] hold_ack;
  int            wait_c [NS];

  initial begin
    bus.s_ACK_I = '0;
    bus.s_DAT_I = '0;
    for (int i = 0; i < NS; i++) wait_c[i] = $urandom_range(0, 2);
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (bus.s_ACK_I[i]) begin
          bus.s_ACK_I[i] = 1'b0;
          wait_c[i] = $urandom_range(0, 2);
        end else if (hold_ack[i]) begin
          bus.s_ACK_I[i] = 1'b0;
        end else if (bus.s_STB_O[i]) begin
          if (wait_c[i] == 0) begin
            logic [34:0] key;
            logic [31:0] cur;
            key = {3'(i), bus.s_ADR_O};
            cur = slv_mem.exists(key) ? slv_mem[key] : default_word(bus.s_ADR_O);
            if (bus.s_WE_O) slv_mem[key] = merge(cur, bus.s_DAT_O, bus.s_SEL_O);
            bus.s_DAT_I[i*DW +: DW] = cur;
            bus.s_ACK_I[i] = 1'b1;
          end else begin
            wait_c[i]--;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          bus.s_ACK_I[i] = 1'b1;
          bus.s_DAT_I[i*DW +: DW] = $urandom;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic prev_err = 1'b0;

  always @(negedge clk) begin
    if (!rst && (bus.ACK_O || bus.ERR_O)) begin
      check("ack_err_exclusive", 96'(bus.ACK_O & bus.ERR_O), 96'(0));
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: ACK_O=%0b ERR_O=%0b with no transfer outstanding", bus.ACK_O, bus.ERR_O);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_kind", 96'(bus.ERR_O), 96'(e.is_err));
        if (e.is_err) begin
          check("err_addr", 96'(err_addr), 96'(e.eaddr));
          check("err_count", 96'(err_count), 96'(e.ecnt));
          check("err_no_strobe", 96'(bus.s_STB_O), 96'(0));
          check("err_dat_zero", 96'(bus.DAT_O), 96'(0));
          check("err_one_cycle", 96'(prev_err), 96'(0));
        end else begin
          logic [NS-1:0] oh;
          oh = '0;
          if (e.slv >= 0) oh[e.slv] = 1'b1;
          check("ack_route", 96'(bus.s_STB_O), 96'(oh));
          check("ack_cyc_route", 96'(bus.s_CYC_O), 96'(oh));
          if (!e.we) check("read_data", 96'(bus.DAT_O), 96'(e.data));
        end
      end
    end
    prev_err = bus.ERR_O;
  end

  // ---------------- driver ----------------
  task automatic do_txn(input logic [31:0] a, input logic we, input logic [3:0] sel, input logic [31:0] d);
    int s;
    logic [NS-1:0] oh;
    bit done;
    s  = decode(a);
    oh = '0;
    if (s >= 0) oh[s] = 1'b1;
    model_txn(a, we, sel, d);
    bus.ADR_I = a;
    bus.DAT_I = d;
    bus.WE_I  = we;
    bus.SEL_I = sel;
    bus.CYC_I = 1'b1;
    bus.STB_I = 1'b1;
    @(negedge clk);
    check("strobe_latency", 96'(bus.s_STB_O), 96'(0));
    check("broadcast", {bus.s_ADR_O, bus.s_DAT_O, 27'(0), bus.s_WE_O, bus.s_SEL_O},
          {a, d, 27'(0), we, sel});
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (!bus.ERR_O) check("strobe_held", 96'(bus.s_STB_O), 96'(oh));
      if (bus.ACK_O || bus.ERR_O) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout: no ACK_O/ERR_O for address 0x%08h within 40 cycles", a);
    end
    @(posedge clk);
    #1;
    bus.CYC_I = 1'b0;
    bus.STB_I = 1'b0;
    bus.WE_I  = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] bad [4];
    int r;
    bad[0] = 32'h2000_0000;
    bad[1] = 32'h8000_0000;
    bad[2] = 32'h1000_1000;
    bad[3] = 32'hF002_0000;
    r = $urandom_range(0, 5);
    if (r < NS) return BASES[r*AW +: AW] | (32'($urandom_range(0, 3)) << 2);
    return bad[$urandom_range(0, 3)] | (32'($urandom_range(0, 3)) << 2);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    hold_ack = '0;
    bus.ADR_I = '0; bus.DAT_I = '0; bus.WE_I = 1'b0; bus.SEL_I = '0;
    bus.CYC_I = 1'b0; bus.STB_I = 1'b0;
    bus2.ADR_I = '0; bus2.DAT_I = '0; bus2.WE_I = 1'b0; bus2.SEL_I = '0;
    bus2.CYC_I = 1'b0; bus2.STB_I = 1'b0; bus2.s_ACK_I = '0; bus2.s_DAT_I = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {bus.ACK_O, bus.ERR_O, 27'(bus.s_STB_O), 32'(bus.DAT_O), 8'(err_count), 2'(dbg_state)}, 96'(0));
    check("reset_err_addr", 96'(err_addr), 96'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    slv_mem[{3'd0, 32'h0000_0010}] = 32'hDEAD_BEEF;
    ref_mem[32'h0000_0010] = 32'hDEAD_BEEF;
    do_txn(32'h0000_0010, 1'b0, 4'hF, 32'h0);
    do_txn(32'hF000_1000, 1'b1, 4'b0001, 32'h41);
    check("err_count_after_write", 96'(err_count), 96'(0));
    do_txn(32'hF000_1000, 1'b0, 4'hF, 32'h0);
    do_txn(32'h2000_0000, 1'b0, 4'hF, 32'h0);

    for (int n = 0; n < 150; n++)
      do_txn(pick_addr(), 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom);

`ifdef WB_INTERCONNECT_TIMEOUT_EN
    begin
      int held;
      held = 0;
      hold_ack[2] = 1'b1;
      model_txn(32'h4000_0000, 1'b0, 4'hF, 32'h0);
      exp_q[exp_q.size()-1].is_err = 1'b1;
      ref_err_addr = 32'h4000_0000;
      if (ref_err_count < 255) ref_err_count++;
      exp_q[exp_q.size()-1].eaddr = ref_err_addr;
      exp_q[exp_q.size()-1].ecnt  = 8'(ref_err_count);
      bus.ADR_I = 32'h4000_0000; bus.WE_I = 1'b0; bus.SEL_I = 4'hF;
      bus.CYC_I = 1'b1; bus.STB_I = 1'b1;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (bus.ERR_O) break;
        if (bus.s_STB_O[2]) held++;
      end
      check("timeout_strobe_cycles", 96'(held), 96'(TMO));
      @(posedge clk);
      #1 bus.CYC_I = 1'b0; bus.STB_I = 1'b0;
      @(negedge clk);
      hold_ack[2] = 1'b0;
    end
`endif

    // master abort while slave 2 is stalled
    hold_ack[2] = 1'b1;
    bus.ADR_I = 32'h4000_0004; bus.WE_I = 1'b0; bus.SEL_I = 4'hF;
    bus.CYC_I = 1'b1; bus.STB_I = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort_strobe_on", 96'(bus.s_STB_O), 96'(5'b00100));
    @(posedge clk);
    #1 bus.CYC_I = 1'b0; bus.STB_I = 1'b0;
    @(negedge clk);
    check("abort_strobe_gated", {bus.ACK_O, bus.ERR_O, 27'(bus.s_STB_O)}, 96'(0));
    @(negedge clk);
    check("abort_idle", 96'(dbg_state), 96'(0));
    check("abort_err_count", 96'(err_count), 96'(ref_err_count));

    // reset in the middle of a second stalled transfer
    bus.CYC_I = 1'b1; bus.STB_I = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_mid_strobe_on", 96'(bus.s_STB_O), 96'(5'b00100));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_mid_outputs", {bus.ACK_O, bus.ERR_O, 27'(bus.s_STB_O), 32'(bus.DAT_O), 8'(err_count), 2'(dbg_state)}, 96'(0));
    check("reset_mid_err_addr", 96'(err_addr), 96'(0));
    bus.CYC_I = 1'b0; bus.STB_I = 1'b0;
    hold_ack[2] = 1'b0;
    ref_err_count = 0;
    ref_err_addr = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    do_txn(32'h2000_0008, 1'b0, 4'hF, 32'h0);

    // overlapping map: slave 0 must win
    bus2.ADR_I = 32'h0000_0004; bus2.SEL_I = 4'hF;
    bus2.CYC_I = 1'b1; bus2.STB_I = 1'b1;
    @(negedge clk);
    check("overlap_latency", 96'(bus2.s_STB_O), 96'(0));
    @(negedge clk);
    check("overlap_lowest_wins", 96'(bus2.s_STB_O), 96'(2'b01));
    bus2.s_DAT_I = {32'h1111_1111, 32'h2222_2222};
    bus2.s_ACK_I = 2'b11;
    #1;
    check("overlap_ack", {bus2.ACK_O, bus2.ERR_O, 32'(bus2.DAT_O)}, {1'b1, 1'b0, 32'h2222_2222});
    @(posedge clk);
    #1 bus2.CYC_I = 1'b0; bus2.STB_I = 1'b0; bus2.s_ACK_I = '0;
    @(negedge clk);
    check("overlap_idle", {bus2.ACK_O, 2'(dbg_state2)}, 96'(0));

    repeat (3) @(negedge clk);
    check("queue_drained", 96'(exp_q.size()), 96'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
